// File: rtl/sweep_learn_ctrl.sv
// Sweep-learning controller: steps the generator, captures the matching FFT bin,
// normalises it to a reference block exponent, stores it and classifies the DUT response.
module sweep_learn_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 12,
    parameter int NUM_POINTS   = 2751,
    parameter int SETTLE_CYC   = 149997,
    parameter int BLK_EXP_NORM = 8,
    parameter int EDGE_THR     = 500,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              freq,
    input  logic                     fft_valid_in,
    input  logic [15:0]              fft_index,
    input  logic signed [DATA_W-1:0] fft_real,
    input  logic signed [DATA_W-1:0] fft_imag,
    input  logic [7:0]               blk_exp,
    output logic                     next_freq,
    output logic                     fft_arm,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_real,
    output logic signed [DATA_W-1:0] wr_imag,
    output logic [DATA_W:0]          mag,
    output logic                     mag_valid,
    output logic                     busy,
    output logic                     learn_done,
    output logic                     timeout_err,
    output logic [2:0]               filter_type
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] NPTS        = 32'(NUM_POINTS);
    localparam int          CW          = DATA_W + 2;
    localparam logic [CW-1:0] THR       = CW'(EDGE_THR);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_SETTLE, S_ARM, S_WRITE, S_MAG1, S_MAG2, S_CLASSIFY
    } state_t;

    state_t            state, next;
    logic [31:0]       cnt;
    logic              start_d1, start_d2, start_rise, go, match, sweep_end;
    int                shift_s;
    logic [DATA_W:0]   abs_re_p1, abs_im_p1;
    logic [DATA_W:0]   ref_mag;
    logic              rise, fall;
    logic [15:0]       pt, rise_idx, fall_idx;
    logic [2:0]        class_type;
    logic [CW-1:0]     mag_x, ref_x;

    function automatic logic signed [DATA_W-1:0] sat_val(input logic neg);
        sat_val = neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    // Positive s: arithmetic right shift; negative s: saturating left shift.
    function automatic logic signed [DATA_W-1:0] normalise(input logic signed [DATA_W-1:0] x,
                                                           input int s);
        logic signed [2*DATA_W-1:0] w;
        logic [DATA_W:0]            top;
        normalise = x;
        if (s >= DATA_W) begin
            normalise = x >>> (DATA_W - 1);
        end else if (s > 0) begin
            normalise = x >>> s;
        end else if (s < 0) begin
            if (-s >= DATA_W) begin
                if (x != '0) normalise = sat_val(x[DATA_W-1]);
            end else begin
                w   = {{DATA_W{x[DATA_W-1]}}, x};
                w   = w <<< (-s);
                top = w[2*DATA_W-1:DATA_W-1];
                if (top == '0 || top == '1) normalise = w[DATA_W-1:0];
                else                        normalise = sat_val(w[2*DATA_W-1]);
            end
        end
    endfunction

    function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W:0] e;
        e = {x[DATA_W-1], x};
        if (e[DATA_W]) e = -e;
        abs_ext = e;
    endfunction

    // max + min/4 + min/8 approximation, saturated to DATA_W+1 bits
    function automatic logic [DATA_W:0] mag_est(input logic [DATA_W:0] a, input logic [DATA_W:0] b);
        logic [DATA_W+1:0] mx, mn, sum;
        mx  = (a >= b) ? {1'b0, a} : {1'b0, b};
        mn  = (a >= b) ? {1'b0, b} : {1'b0, a};
        sum = mx + (mn >> 2) + (mn >> 3);
        mag_est = sum[DATA_W+1] ? '1 : sum[DATA_W:0];
    endfunction

    assign start_rise = start_d1 & ~start_d2;
    assign go         = (state == S_IDLE) && start_rise && !abort;
    assign match      = fft_valid_in && (fft_index == freq);
    assign sweep_end  = {16'd0, freq} >= NPTS;
    assign shift_s    = BLK_EXP_NORM - int'({24'd0, blk_exp});
    assign mag_x      = {1'b0, mag};
    assign ref_x      = {1'b0, ref_mag};

    always_ff @(posedge clk_50m) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        if (abort) begin
            next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (start_rise) next = S_STEP;
                S_STEP:     next = sweep_end ? S_CLASSIFY : S_SETTLE;
                S_SETTLE:   if (cnt == SETTLE_LAST) next = S_ARM;
                S_ARM:      if (match || cnt == TO_LAST) next = S_WRITE;
                S_WRITE:    next = S_MAG1;
                S_MAG1:     next = S_MAG2;
                S_MAG2:     next = S_STEP;
                S_CLASSIFY: next = S_IDLE;
                default:    next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        next_freq = (state == S_STEP) && !sweep_end && !abort;
        fft_arm   = (state == S_ARM) && !abort;
        wr_en     = (state == S_WRITE) && !abort;
        mag_valid = (state == S_MAG2) && !abort;
        busy      = (state != S_IDLE);
    end

    always_comb begin
        if (!rise && !fall)     class_type = 3'd0;
        else if (rise && !fall) class_type = 3'd1;
        else if (!rise && fall) class_type = 3'd2;
        else if (rise_idx < fall_idx) class_type = 3'd3;
        else                    class_type = 3'd4;
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            cnt         <= '0;
            start_d1    <= 1'b0;
            start_d2    <= 1'b0;
            learn_done  <= 1'b1;
            timeout_err <= 1'b0;
            wr_addr     <= '0;
            filter_type <= '0;
            ref_mag     <= '0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            rise_idx    <= '0;
            fall_idx    <= '0;
            pt          <= '0;
        end else begin
            start_d1 <= start;
            start_d2 <= start_d1;
            cnt      <= (state != next) ? '0 : cnt + 32'd1;
            if (go) begin
                learn_done  <= 1'b0;
                timeout_err <= 1'b0;
                wr_addr     <= '0;
                rise        <= 1'b0;
                fall        <= 1'b0;
                pt          <= '0;
            end
            if (state == S_ARM && !abort && !match && cnt == TO_LAST) timeout_err <= 1'b1;
            if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
            if (mag_valid) begin
                pt <= pt + 16'd1;
                if (pt == '0) begin
                    ref_mag <= mag;
                end else if (mag_x >= ref_x + THR) begin
                    ref_mag <= mag;
                    rise    <= 1'b1;
                    if (!rise) rise_idx <= pt;
                end else if (ref_x >= mag_x + THR) begin
                    ref_mag <= mag;
                    fall    <= 1'b1;
                    if (!fall) fall_idx <= pt;
                end
            end
            if (state == S_CLASSIFY && !abort) begin
                filter_type <= class_type;
                learn_done  <= 1'b1;
            end
        end
    end

    // Capture into WRITE: normalised bin, or zeros on timeout
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            wr_real <= '0;
            wr_imag <= '0;
            mag     <= '0;
        end else begin
            if (state == S_ARM && next == S_WRITE) begin
                wr_real <= match ? normalise(fft_real, shift_s) : '0;
                wr_imag <= match ? normalise(fft_imag, shift_s) : '0;
            end
            if (state == S_MAG1) mag <= mag_est(abs_re_p1, abs_im_p1);
        end
    end

    // Magnitude stage 1: absolute values of the written point
    always_ff @(posedge clk_50m) begin
        if (state == S_WRITE) begin
            abs_re_p1 <= abs_ext(wr_real);
            abs_im_p1 <= abs_ext(wr_imag);
        end
    end

endmodule

// File: tb/tb_sweep_learn_ctrl.sv
// Directed bench for sweep_learn_ctrl: a generator/FFT responder drives the DUT,
// expected writes and magnitudes are queued per sweep and popped as the DUT strobes them.
module tb_sweep_learn_ctrl;
    localparam int DW = 16, AW = 12, NP = 8, SC = 4, TO = 16;

    logic                 clk_50m = 1'b0;
    logic                 rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [15:0]          freq = '0;
    logic                 fft_valid_in = 1'b0;
    logic [15:0]          fft_index = '0;
    logic signed [DW-1:0] fft_real = '0, fft_imag = '0;
    logic [7:0]           blk_exp = '0;
    logic                 next_freq, fft_arm, wr_en, mag_valid, busy, learn_done, timeout_err;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_real, wr_imag;
    logic [DW:0]          mag;
    logic [2:0]           filter_type;

    sweep_learn_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_POINTS(NP), .SETTLE_CYC(SC),
                       .BLK_EXP_NORM(8), .EDGE_THR(500), .TIMEOUT_CYC(TO)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .abort(abort), .freq(freq),
        .fft_valid_in(fft_valid_in), .fft_index(fft_index), .fft_real(fft_real),
        .fft_imag(fft_imag), .blk_exp(blk_exp), .next_freq(next_freq), .fft_arm(fft_arm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_real(wr_real), .wr_imag(wr_imag), .mag(mag),
        .mag_valid(mag_valid), .busy(busy), .learn_done(learn_done),
        .timeout_err(timeout_err), .filter_type(filter_type));

    always #10 clk_50m = ~clk_50m;

    typedef struct { int addr; int re; int im; } wr_t;
    wr_t wr_q[$];
    int  mag_q[$];
    int  p_re[NP], p_im[NP], p_exp[NP], e_mag[NP], arm_len[NP];
    bit  p_to[NP];
    int  checks = 0, failures = 0;
    int  exp_ft, last_ft;
    bit  exp_to;

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int m_norm(int x, int e);
        int s; longint d, v;
        s = 8 - e;
        if (s > 0) begin
            d = longint'(1) << s;
            v = x / d;
            if ((x % d) != 0 && x < 0) v = v - 1;
        end else if (s < 0) begin
            if (-s > 40) v = (x > 0) ? 40'hFF_FFFF_FFFF : ((x < 0) ? -64'sd1099511627775 : 0);
            else v = longint'(x) * (longint'(1) << (-s));
        end else v = x;
        return clamp16(v);
    endfunction

    function automatic int m_mag(int re, int im);
        int a, b, mx, mn, v;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        v = mx + mn / 4 + mn / 8;
        return (v > 131071) ? 131071 : v;
    endfunction

    function automatic int m_class(int n);
        int refm = 0, ri = 0, fi = 0;
        bit r = 0, f = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) refm = e_mag[i];
            else if (e_mag[i] >= refm + 500) begin if (!r) ri = i; r = 1; refm = e_mag[i]; end
            else if (refm >= e_mag[i] + 500) begin if (!f) fi = i; f = 1; refm = e_mag[i]; end
        end
        if (!r && !f) return 0;
        if (r && !f) return 1;
        if (!r && f) return 2;
        return (ri < fi) ? 3 : 4;
    endfunction

    task automatic set_pt(input int i, input int re, input int im, input int e, input bit to);
        p_re[i] = re; p_im[i] = im; p_exp[i] = e; p_to[i] = to;
    endtask

    task automatic set_mags(input int m0, input int m1, input int m2, input int m3, input int tail);
        set_pt(0, m0, 0, 8, 0); set_pt(1, m1, 0, 8, 0); set_pt(2, m2, 0, 8, 0); set_pt(3, m3, 0, 8, 0);
        for (int i = 4; i < NP; i++) set_pt(i, tail, 0, 8, 0);
    endtask

    task automatic load_expect(input int n);
        int re, im;
        exp_to = 0;
        for (int i = 0; i < n; i++) begin
            re = p_to[i] ? 0 : m_norm(p_re[i], p_exp[i]);
            im = p_to[i] ? 0 : m_norm(p_im[i], p_exp[i]);
            wr_q.push_back('{i, re, im});
            e_mag[i] = m_mag(re, im);
            mag_q.push_back(e_mag[i]);
            exp_to |= p_to[i];
        end
        exp_ft = m_class(n);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_50m); @(negedge clk_50m);
        start = 1'b0;
    endtask

    task automatic run_sweep(input string tag);
        int n;
        load_expect(NP);
        pulse_start();
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk_50m);
            n++;
            if (n == 40) start = 1'b1;   // start while busy must be ignored
            if (n == 43) start = 1'b0;
        end
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_learn_done"}, learn_done, 1);
        chk({tag, "_filter_type"}, filter_type, exp_ft);
        chk({tag, "_timeout_err"}, timeout_err, exp_to);
        chk({tag, "_writes_left"}, wr_q.size(), 0);
        chk({tag, "_mags_left"}, mag_q.size(), 0);
        last_ft = exp_ft;
        repeat (3) @(negedge clk_50m);
    endtask

    // Generator and FFT responder
    initial begin
        bit inc_pend = 0;
        int arm_cnt = 0, pidx;
        forever begin
            @(negedge clk_50m);
            if (!busy) begin
                freq = '0; inc_pend = 0; arm_cnt = 0; fft_valid_in = 1'b0;
            end else begin
                if (inc_pend) freq = freq + 16'd1;
                inc_pend = next_freq;
                pidx = int'(freq) - 1;
                if (pidx < 0) pidx = 0;
                if (pidx > NP - 1) pidx = NP - 1;
                fft_valid_in = 1'b1;
                if (fft_arm) begin
                    arm_cnt++;
                    arm_len[pidx] = arm_cnt;
                    fft_real = DW'(p_re[pidx]);
                    fft_imag = DW'(p_im[pidx]);
                    blk_exp = 8'(p_exp[pidx]);
                    fft_index = (arm_cnt == 3 && !p_to[pidx]) ? freq : freq + 16'd1000;
                end else begin
                    // matching bin with junk data outside the capture window
                    arm_cnt = 0;
                    fft_index = freq;
                    fft_real = 16'sd12345;
                    fft_imag = -16'sd1;
                    blk_exp = 8'd0;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        wr_t e;
        int  m;
        forever begin
            @(negedge clk_50m);
            if (rst_n) begin
                if (wr_en) begin
                    if (wr_q.size() == 0) chk("wr_unexpected", wr_en, 0);
                    else begin
                        e = wr_q.pop_front();
                        chk("wr_addr", wr_addr, e.addr);
                        chk("wr_real", wr_real, e.re);
                        chk("wr_imag", wr_imag, e.im);
                    end
                end
                if (mag_valid) begin
                    if (mag_q.size() == 0) chk("mag_unexpected", mag_valid, 0);
                    else begin
                        m = mag_q.pop_front();
                        chk("mag", mag, m);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_learn_done"}, learn_done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_filter_type"}, filter_type, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_mag"}, mag, 0);
        chk({tag, "_strobes"}, {next_freq, fft_arm, wr_en, mag_valid}, 0);
    endtask

    initial begin
        int n, pulses;
        repeat (3) @(negedge clk_50m);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk_50m);

        for (int i = 0; i < NP; i++) set_pt(i, 1000, 0, 8, 0);
        run_sweep("flat");

        set_pt(0, -1000, 0, 6, 0);      set_pt(1, 20000, 0, 10, 0);
        set_pt(2, -32768, -32768, 8, 0); set_pt(3, 1234, -567, 8, 0);
        set_pt(4, -5, 3, 12, 0);         set_pt(5, 300, -300, 20, 0);
        set_pt(6, -20000, 100, 0, 0);    set_pt(7, 7, -7, 40, 0);
        run_sweep("norm");

        set_mags(4000, 4000, 1000, 1000, 1000); run_sweep("lowpass");
        set_mags(100, 900, 900, 100, 100);      run_sweep("bandpass");
        set_mags(3000, 200, 200, 3000, 3000);   run_sweep("bandstop");
        set_mags(200, 200, 3000, 3000, 3000);   run_sweep("highpass");

        for (int i = 0; i < NP; i++) set_pt(i, 1000, 0, 8, i == 2);
        run_sweep("timeout");
        chk("timeout_arm_len", arm_len[2], TO);
        chk("match_arm_len", arm_len[1], 3);

        // abort in SETTLE of point 3
        for (int i = 0; i < NP; i++) set_pt(i, 1000, 0, 8, 0);
        load_expect(3);
        pulse_start();
        n = 0; pulses = 0;
        while (pulses < 4 && n < 1000) begin
            if (next_freq) pulses++;
            if (pulses < 4) begin @(negedge clk_50m); n++; end
        end
        chk("abort_reach_point3", pulses, 4);
        @(negedge clk_50m);
        abort = 1'b1;
        chk("abort_cycle_strobes", {next_freq, fft_arm, wr_en}, 0);
        @(negedge clk_50m);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_learn_done", learn_done, 0);
        chk("abort_filter_type", filter_type, last_ft);
        repeat (30) @(negedge clk_50m);
        chk("abort_writes_left", wr_q.size(), 0);
        chk("abort_still_idle", busy, 0);

        run_sweep("restart");

        // reset mid-sweep
        set_mags(4000, 4000, 1000, 1000, 1000);
        load_expect(NP);
        pulse_start();
        repeat (40) @(negedge clk_50m);
        chk("midsweep_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk_50m);
        chk_reset("midreset");
        rst_n = 1'b1;
        wr_q.delete();
        mag_q.delete();
        repeat (5) @(negedge clk_50m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
